// File: rtl/cussen_pkg.sv
// Shared types and helpers for the cussen_stream sort/dedup/delta block.
// Holds the FSM state enum, output word kinds and a width helper.
`timescale 1ns/1ps
package cussen_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DELTA,
    ST_PTR
  } state_t;

  localparam logic KIND_DELTA = 1'b0;
  localparam logic KIND_PTR   = 1'b1;

  // $clog2 that never returns 0, so a 1-entry table still gets a pointer bit
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/uniq_sort_table.sv
// Sorted, duplicate-free value table with parallel compare and insert.
// Ports: i_clr/i_ins/i_key update, o_hit/o_pos lookup, o_cnt, read port.
`timescale 1ns/1ps
module uniq_sort_table
  import cussen_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 9,
  localparam int PW = clog2_min1(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_ins,
  input  logic [W-1:0]  i_key,
  input  logic [PW-1:0] i_rd_idx,
  output logic          o_hit,
  output logic [CW-1:0] o_pos,
  output logic [CW-1:0] o_cnt,
  output logic [W-1:0]  o_rd_cur,
  output logic [W-1:0]  o_rd_prev
);

  logic [W-1:0]  r_tab [N];
  logic [CW-1:0] r_cnt;
  logic          w_hit;
  logic [CW-1:0] w_pos;
  logic          w_ins;

  // pos = number of live entries below key; equals rank on a hit
  always_comb begin
    w_hit = 1'b0;
    w_pos = '0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < r_cnt) begin
        if (r_tab[i] == i_key)
          w_hit = 1'b1;
        if (r_tab[i] < i_key)
          w_pos = w_pos + CW'(1);
      end
    end
  end

  assign w_ins = i_ins && !w_hit;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (w_ins)
      r_cnt <= r_cnt + CW'(1);
  end

  // entries at or above pos move up one slot, key lands at pos
  always_ff @(posedge clk) begin
    if (w_ins) begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) == w_pos)
          r_tab[i] <= i_key;
        else if (CW'(i) > w_pos)
          r_tab[i] <= r_tab[(i > 0) ? i - 1 : 0];
      end
    end
  end

  assign o_hit    = w_hit;
  assign o_pos    = w_pos;
  assign o_cnt    = r_cnt;
  assign o_rd_cur = r_tab[i_rd_idx];
  // prev of entry 0 reads as 0 so the first delta is the value itself
  assign o_rd_prev = (i_rd_idx == '0) ? '0
                   : r_tab[i_rd_idx - PW'(1)];

endmodule

// File: rtl/cussen_stream.sv
// Streaming sort/dedup/delta coder: loads a frame, then emits deltas and ranks.
// Ports: in_* sample stream, out_* word stream, uniq_count/frame_len stats.
`timescale 1ns/1ps
module cussen_stream
  import cussen_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 9,
  localparam int PW = clog2_min1(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_kind,
  output logic          out_last,
  output logic [CW-1:0] uniq_count,
  output logic [CW-1:0] frame_len
);

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_raw [N];
  logic [PW-1:0] r_idx;
  logic [CW-1:0] r_k;

  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_close;
  logic          w_delta_end;
  logic          w_ptr_end;
  logic          w_hit;
  logic [CW-1:0] w_pos;
  logic [CW-1:0] w_cnt;
  logic [W-1:0]  w_key;
  logic [W-1:0]  w_cur;
  logic [W-1:0]  w_prev;

  assign in_ready    = (r_state == ST_LOAD) && !rst;
  assign w_in_hs     = in_valid && in_ready;
  assign w_out_hs    = out_valid && out_ready;
  assign w_close     = w_in_hs
                    && (in_last || r_idx == PW'(N - 1));
  assign w_delta_end = (r_k == uniq_count - CW'(1));
  assign w_ptr_end   = (r_k == frame_len - CW'(1));

  // comparators are shared: incoming sample in LOAD, stored sample in PTR
  assign w_key = (r_state == ST_PTR) ? r_raw[r_k[PW-1:0]]
                                     : in_data;

  uniq_sort_table #(
    .W(W),
    .N(N)
  ) u_tab (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_out_hs && r_state == ST_PTR && w_ptr_end),
    .i_ins    (w_in_hs),
    .i_key    (w_key),
    .i_rd_idx (r_k[PW-1:0]),
    .o_hit    (w_hit),
    .o_pos    (w_pos),
    .o_cnt    (w_cnt),
    .o_rd_cur (w_cur),
    .o_rd_prev(w_prev)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_LOAD;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_LOAD:  if (w_close) w_next = ST_DELTA;
      ST_DELTA: if (w_out_hs && w_delta_end) w_next = ST_PTR;
      ST_PTR:   if (w_out_hs && w_ptr_end) w_next = ST_LOAD;
      default:  w_next = ST_LOAD;
    endcase
  end

  // words are decoded from registered state/counters, so they stay
  // stable for as long as the consumer stalls
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_kind  = KIND_DELTA;
    out_last  = 1'b0;
    unique case (r_state)
      ST_DELTA: begin
        out_valid = 1'b1;
        out_data  = w_cur - w_prev;
      end
      ST_PTR: begin
        out_valid = 1'b1;
        out_kind  = KIND_PTR;
        out_data  = W'(w_pos);
        out_last  = w_ptr_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_k        <= '0;
      uniq_count <= '0;
      frame_len  <= '0;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          if (w_in_hs)
            r_idx <= r_idx + PW'(1);
          if (w_close) begin
            // table count is updated on the same edge, so add the miss here
            uniq_count <= w_hit ? w_cnt : w_cnt + CW'(1);
            frame_len  <= CW'(r_idx) + CW'(1);
            r_k        <= '0;
          end
        end
        ST_DELTA: begin
          if (w_out_hs)
            r_k <= w_delta_end ? '0 : r_k + CW'(1);
        end
        ST_PTR: begin
          if (w_out_hs) begin
            if (w_ptr_end) begin
              r_k   <= '0;
              r_idx <= '0;
            end else begin
              r_k <= r_k + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_hs)
      r_raw[r_idx] <= in_data;
  end

endmodule

// File: tb/tb_cussen_stream.sv
// Directed bench for cussen_stream with hand-computed word sequences.
// Drives on the falling edge, samples #1 later, checks via chk().
`timescale 1ns/1ps
module tb_cussen_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_kind;
  logic       out_last;
  logic [3:0] uniq_count;
  logic [3:0] frame_len;

  int n_chk  = 0;
  int n_pass = 0;

  int din[$];
  int dq[$];
  int pq[$];

  always #5 clk = ~clk;

  cussen_stream #(
    .W(8),
    .N(9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_kind  (out_kind),
    .out_last  (out_last),
    .uniq_count(uniq_count),
    .frame_len (frame_len)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // lastpos: sample index carrying in_last (-1 = none)
  // stop_at: leave after this many output handshakes (-1 = full frame)
  task automatic run_frame(input string tag, input int lastpos,
                           input bit rnd, input int stop_at,
                           input int exp_u, input int exp_n);
    int si = 0;
    int oi = 0;
    int cyc = 0;
    int nd = dq.size();
    int tot = dq.size() + pq.size();
    bit stalled = 0;
    bit pend = 0;
    bit pdone = 0;
    int held = 0;
    int ed;
    int ek;
    int el;
    while (oi < tot && oi != stop_at && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk($sformatf("%s_hold_v", tag), out_valid, 1);
        chk($sformatf("%s_hold_d", tag), out_data, held);
      end
      if (pend && !pdone) begin
        chk($sformatf("%s_rdy_closed", tag), in_ready, 0);
        pdone = 1;
      end
      if (si < din.size() && (!rnd || $urandom_range(1) == 1)) begin
        in_valid = 1'b1;
        in_data  = 8'(din[si]);
        in_last  = (si == lastpos);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      out_ready = rnd ? ($urandom_range(1) == 1) : 1'b1;
      #1;
      if (in_valid && in_ready) begin
        si++;
        if (si == din.size())
          pend = 1;
      end
      if (out_valid && out_ready) begin
        if (oi < nd) begin
          ed = dq[oi];
          ek = 0;
          el = 0;
        end else begin
          ed = pq[oi - nd];
          ek = 1;
          el = (oi == tot - 1) ? 1 : 0;
        end
        chk($sformatf("%s_w%0d_data", tag, oi), out_data, ed);
        chk($sformatf("%s_w%0d_kind", tag, oi), out_kind, ek);
        chk($sformatf("%s_w%0d_last", tag, oi), out_last, el);
        oi++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (stop_at < 0) begin
      chk($sformatf("%s_words", tag), oi, tot);
      @(negedge clk);
      #1;
      chk($sformatf("%s_uniq", tag), uniq_count, exp_u);
      chk($sformatf("%s_len", tag), frame_len, exp_n);
      chk($sformatf("%s_idle_v", tag), out_valid, 0);
      chk($sformatf("%s_idle_rdy", tag), in_ready, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_kind", out_kind, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_uniq", uniq_count, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    din = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
    dq  = '{1, 1, 1, 1, 1, 1, 3};
    pq  = '{2, 0, 3, 0, 4, 6, 1, 5, 4};
    run_frame("t1", 8, 0, -1, 7, 9);

    din = '{0, 0, 7, 0};
    dq  = '{0, 7};
    pq  = '{0, 0, 1, 0};
    run_frame("t2", 3, 0, -1, 2, 4);

    din = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    dq  = '{255};
    pq  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame("t3", -1, 0, -1, 1, 9);

    din = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
    dq  = '{1, 1, 1, 1, 1, 1, 3};
    pq  = '{2, 0, 3, 0, 4, 6, 1, 5, 4};
    run_frame("t4", 8, 1, -1, 7, 9);

    run_frame("t5a", 8, 0, 2, 7, 9);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_uniq", uniq_count, 0);
    rst = 1'b0;
    #1;
    chk("t5_rel_in_ready", in_ready, 1);
    din = '{5, 5};
    dq  = '{5};
    pq  = '{0, 0};
    run_frame("t5b", 1, 0, -1, 1, 2);

    din = '{42};
    dq  = '{42};
    pq  = '{0};
    run_frame("t6", 0, 0, -1, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
